aes_256_round_ctrl: RTL and testbench
=====================================

// Module: aes_256_round_ctrl
// PURPOSE
//  Round sequencer that drives the AES-256 state datapath through a full cipher
//  or inverse-cipher pass. It generates current_state, round and cnt, plus the
//  mode lines mode_switch and inv_en.
//  Start/busy/done handshake toward the CTR-mode top; one block in flight.
// PARAMETERS
//  NR          14  number of cipher rounds (AES-256)
//  ARK_CYCLES  7   AddRoundKey dwell for non-initial rounds; datapath commits at cnt==ARK_CYCLES-1 (6)
// PORTS
//  clk           in   1  clock
//  rst_n         in   1  reset, asynchronous, active-low
//  start         in   1  request one block; sampled only in IDLE
//  inv_req       in   1  0=encrypt, 1=decrypt; sampled with start
//  busy          out  1  high from the cycle after start acceptance through DONE
//  done          out  1  one-cycle pulse in DONE state
//  current_state out  4  phase code driven to the datapath (aes_pkg encoding)
//  round         out  4  current round number 0..NR
//  cnt           out  5  signed intra-phase counter
//  mode_switch   out  1  latched inv_req; selects inverse S-box/shift/mix
//  inv_en        out  1  latched inv_req; selects round-numbering direction
// BEHAVIOUR
//  Reset: IDLE; busy=0, done=0, current_state=IDLE, round=0, cnt=0, mode_switch=0, inv_en=0.
//  IDLE & start:
//   - latch inv_req into mode_switch and inv_en.
//   - next cycle: enc -> ARK, round=0; dec -> I_ARK, round=NR; cnt=0.
//  Phase dwell (cnt counts 0,1,.. and resets to 0 on every phase change):
//   - SB/I_SB: 16 cycles, cnt 0..15 (byte index).
//   - SR/I_SR: 1 cycle, cnt=0.
//   - MC/I_MC: 4 cycles, cnt 0..3 (column index).
//   - ARK/I_ARK: ARK_CYCLES cycles, cnt 0..6.
//   - Exception: initial ARK (enc round 0, dec round NR) lasts exactly 1 cycle with cnt=0.
//  Encrypt order:
//   - round 0: ARK.
//   - rounds 1..NR-1: SB,SR,MC,ARK.
//   - round NR: SB,SR,ARK.
//   - round increments on leaving ARK.
//  Decrypt order:
//   - round NR: I_ARK.
//   - rounds NR-1..1: I_SR,I_SB,I_ARK,I_MC.
//   - round 0: I_SR,I_SB,I_ARK.
//   - round decrements on entering I_SR.
//  After final ARK/I_ARK (cnt=6): DONE for 1 cycle (done=1, cnt=0, round held), then IDLE.
//  Latency: start sampled at T -> first phase at T+1, final commit at T+389, done at T+390,
//   IDLE at T+391. Same for both directions (1+13*28+24).
//  start while busy or in DONE: ignored, no queuing. inv_req changes mid-block: ignored.
//  cnt never exceeds its phase maximum. round never outside 0..NR.
//  Reset mid-operation: immediate return to reset values; no done pulse.
// STRUCTURE
//  aes_pkg holds:
//   - phase codes: IDLE=0, AddRoundKey=1, SubBytes=2, ShiftRows=3, MixColumns=4,
//     I_AddRoundKey=5, I_SubBytes=6, I_ShiftRows=7, I_MixColumns=8, DONE=9.
//   - per-phase dwell constants (SB_LAST=15, MC_LAST=3, ARK_LAST=6).
//  Single module; phase FSM + round counter + cnt counter, no sub-modules.
//  Next-phase logic is a function of (phase, round, inv_en).
// TESTING
//  1. start=1, inv_req=0 at T:
//     - T+1: ARK, round 0, cnt 0.
//     - T+2: SubBytes, round 1, cnt 0.
//     - done exactly at T+390, busy low at T+391.
//  2. Encrypt with datapath: FIPS-197 C.3 vectors; key 000102..1f, pt 00112233..ff ->
//     ct 8ea2b7ca516745bfeafc49904b496089.
//  3. Decrypt (inv_req=1) of the C.3 ciphertext -> 00112233445566778899aabbccddeeff.
//     Check I_ARK round 14 first, then round sequence 13..0.
//  4. Assert start every cycle during a block -> no restart; exactly one done per accepted start.
//  5. Deassert rst_n at round 7 MixColumns cnt 2 -> outputs reset values same cycle, no done.
//     Next start runs a full 389-cycle pass.
//  6. Back-to-back: start high in the IDLE cycle right after done -> second block starts,
//     with period 391 cycles between done pulses.

Source files
------------

// File: rtl/aes_pkg.sv
// Phase encoding, dwell limits and the phase-sequencing rules shared by the
// AES-256 round controller and the state datapath.
package aes_pkg;

    localparam int NR         = 14;
    localparam int ARK_CYCLES = 7;

    localparam logic [4:0] SB_LAST    = 5'd15;
    localparam logic [4:0] MC_LAST    = 5'd3;
    localparam logic [4:0] ARK_LAST   = 5'(ARK_CYCLES - 1);
    localparam logic [3:0] ROUND_LAST = 4'(NR);

    typedef enum logic [3:0] {
        PH_IDLE  = 4'd0,
        PH_ARK   = 4'd1,
        PH_SB    = 4'd2,
        PH_SR    = 4'd3,
        PH_MC    = 4'd4,
        PH_I_ARK = 4'd5,
        PH_I_SB  = 4'd6,
        PH_I_SR  = 4'd7,
        PH_I_MC  = 4'd8,
        PH_DONE  = 4'd9
    } phase_e;

    // Last cnt value of a phase; the initial key addition is a single cycle.
    function automatic logic [4:0] phase_last(input phase_e ph, input logic [3:0] round);
        logic [4:0] last;
        last = '0;
        case (ph)
            PH_SB, PH_I_SB: last = SB_LAST;
            PH_MC, PH_I_MC: last = MC_LAST;
            PH_ARK:         last = (round == '0)         ? '0 : ARK_LAST;
            PH_I_ARK:       last = (round == ROUND_LAST) ? '0 : ARK_LAST;
            default:        last = '0;
        endcase
        return last;
    endfunction

    function automatic phase_e next_phase(input phase_e ph, input logic [3:0] round,
                                          input logic inv_en);
        phase_e nxt;
        nxt = PH_IDLE;
        case (ph)
            PH_IDLE:  nxt = inv_en ? PH_I_ARK : PH_ARK;
            PH_ARK:   nxt = (round == ROUND_LAST) ? PH_DONE : PH_SB;
            PH_SB:    nxt = PH_SR;
            PH_SR:    nxt = (round == ROUND_LAST) ? PH_ARK : PH_MC;
            PH_MC:    nxt = PH_ARK;
            PH_I_ARK: begin
                if (round == ROUND_LAST)
                    nxt = PH_I_SR;
                else if (round == '0)
                    nxt = PH_DONE;
                else
                    nxt = PH_I_MC;
            end
            PH_I_SR:  nxt = PH_I_SB;
            PH_I_SB:  nxt = PH_I_ARK;
            PH_I_MC:  nxt = PH_I_SR;
            default:  nxt = PH_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/aes_256_round_ctrl.sv
// Round sequencer for the AES-256 state datapath: walks one block through the
// cipher or inverse-cipher phase order and reports start/busy/done.
module aes_256_round_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inv_req,
    output logic              busy,
    output logic              done,
    output logic [3:0]        current_state,
    output logic [3:0]        round,
    output logic signed [4:0] cnt,
    output logic              mode_switch,
    output logic              inv_en
);

    phase_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [4:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    phase_e     phase_nxt;
    logic       phase_end;

    assign phase_nxt = next_phase(state_q, round_q, mode_q);
    assign phase_end = (cnt_q == phase_last(state_q, round_q));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is asynchronous and clears all of them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PH_IDLE;
            round_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: every next-state variable gets a hold default before the case, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            PH_IDLE: begin
                if (start) begin
                    state_d = next_phase(PH_IDLE, round_q, inv_req);
                    round_d = inv_req ? ROUND_LAST : '0;
                    cnt_d   = '0;
                    mode_d  = inv_req;
                end
            end
            PH_DONE: begin
                state_d = PH_IDLE;
                cnt_d   = '0;
            end
            default: begin
                if (phase_end) begin
                    state_d = phase_nxt;
                    cnt_d   = '0;
                    // Encrypt advances leaving ARK; decrypt steps down entering I_SR.
                    if (phase_nxt == PH_SB)
                        round_d = round_q + 4'd1;
                    else if (phase_nxt == PH_I_SR)
                        round_d = round_q - 4'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q != PH_IDLE);
        done = (state_q == PH_DONE);
    end

    assign current_state = state_q;
    assign round         = round_q;
    assign cnt           = $signed(cnt_q);
    assign mode_switch   = mode_q;
    assign inv_en        = mode_q;

endmodule

// File: tb/tb_aes_256_round_ctrl.sv
// Directed bench for aes_256_round_ctrl: a byte-serial AES-256 model follows the
// controller's phase/round/cnt outputs and must reproduce the FIPS-197 C.3 vectors.
`timescale 1ns/1ps
module tb_aes_256_round_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_ARK = 4'd1, S_SB = 4'd2, S_SR = 4'd3,
                           S_MC = 4'd4, S_IARK = 4'd5, S_ISB = 4'd6, S_ISR = 4'd7,
                           S_IMC = 4'd8, S_DONE = 4'd9;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              inv_req = 1'b0;
    logic              busy, done, mode_switch, inv_en;
    logic [3:0]        current_state, round;
    logic signed [4:0] cnt;

    int n_checks = 0, n_pass = 0, bad_inv = 0;
    int cyc = 0, done_total = 0, last_done = 0, prev_done = 0;

    logic [7:0]  st [16];
    logic [31:0] w  [60];

    always #5 clk = ~clk;

    aes_256_round_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .inv_req       (inv_req),
        .busy          (busy),
        .done          (done),
        .current_state (current_state),
        .round         (round),
        .cnt           (cnt),
        .mode_switch   (mode_switch),
        .inv_en        (inv_en)
    );

    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
            done_total++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    task automatic expand_key();
        logic [255:0] k = KEY;
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
    endtask

    task automatic shift_rows(input bit inv);
        logic [7:0] o [16];
        for (int i = 0; i < 16; i++) o[i] = st[i];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                st[r + 4*c] = inv ? o[r + 4*((c + 4 - r) % 4)] : o[r + 4*((c + r) % 4)];
    endtask

    task automatic mix_col(input int c, input bit inv);
        logic [7:0] a [4];
        logic [7:0] coef [4];
        logic [7:0] r;
        if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int j = 0; j < 4; j++) a[j] = st[4*c + j];
        for (int j = 0; j < 4; j++) begin
            r = '0;
            for (int m = 0; m < 4; m++) r ^= gmul(a[(j + m) % 4], coef[m]);
            st[4*c + j] = r;
        end
    endtask

    task automatic add_key(input int r);
        for (int i = 0; i < 16; i++) st[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
    endtask

    // One cycle of the reference datapath, driven by what the controller shows.
    task automatic model_step();
        int c = int'(cnt);
        int mx;
        case (current_state)
            S_SB:   if (c < 16) st[c] = sbox(st[c]);
            S_ISB:  if (c < 16) st[c] = inv_sbox(st[c]);
            S_SR:   shift_rows(1'b0);
            S_ISR:  shift_rows(1'b1);
            S_MC:   if (c < 4) mix_col(c, 1'b0);
            S_IMC:  if (c < 4) mix_col(c, 1'b1);
            S_ARK:  if (c == 6 || (c == 0 && round == 4'd0))  add_key(int'(round));
            S_IARK: if (c == 6 || (c == 0 && round == 4'd14)) add_key(int'(round));
            default: ;
        endcase
        case (current_state)
            S_SB, S_ISB:   mx = 15;
            S_MC, S_IMC:   mx = 3;
            S_ARK, S_IARK: mx = 6;
            default:       mx = 0;
        endcase
        if (c < 0 || c > mx || round > 4'd14) bad_inv++;
    endtask

    // Runs one block starting from a negedge; cycle T+k is observed at iteration k.
    task automatic run_block(input string tag, input logic inv, input logic spam,
                             input logic chain, input logic pre,
                             input logic [127:0] din, output logic [127:0] dout);
        int done_at = 0;
        int n_done  = 0;
        int exp_r   = 13;
        for (int i = 0; i < 16; i++) st[i] = din[127 - 8*i -: 8];
        if (!pre) begin
            @(negedge clk);
            start   = 1'b1;
            inv_req = inv;
        end
        @(negedge clk);
        start = spam;
        if (spam) inv_req = ~inv;
        for (int k = 1; k <= 391; k++) begin
            if (k == 1) begin
                check({tag, "_k1_state"}, current_state, inv ? S_IARK : S_ARK);
                check({tag, "_k1_round"}, round, inv ? 4'd14 : 4'd0);
                check({tag, "_k1_cnt"}, cnt, 0);
                check({tag, "_k1_busy"}, busy, 1'b1);
                check({tag, "_k1_mode"}, mode_switch, inv);
                check({tag, "_k1_inv_en"}, inv_en, inv);
            end
            if (k == 2) begin
                check({tag, "_k2_state"}, current_state, inv ? S_ISR : S_SB);
                check({tag, "_k2_round"}, round, inv ? 4'd13 : 4'd1);
                check({tag, "_k2_cnt"}, cnt, 0);
            end
            if (inv && current_state == S_ISR) begin
                check($sformatf("%s_dec_round_%0d", tag, exp_r), round, exp_r);
                exp_r--;
            end
            model_step();
            if (done === 1'b1) begin
                n_done++;
                done_at = k;
            end
            if (spam && k >= 390) start = 1'b0;
            if (k == 391) begin
                check({tag, "_idle_state"}, current_state, S_IDLE);
                check({tag, "_idle_busy"}, busy, 1'b0);
                if (chain) begin
                    start   = 1'b1;
                    inv_req = ~inv;
                end else begin
                    start = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_at"}, done_at, 390);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_mode_held"}, mode_switch, inv);
        for (int i = 0; i < 16; i++) dout[127 - 8*i -: 8] = st[i];
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        bit           found;
        int           d0;

        expand_key();

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", current_state, S_IDLE);
        check("rst_round", round, 0);
        check("rst_cnt", cnt, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mode", mode_switch, 1'b0);
        check("rst_inv_en", inv_en, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", current_state, S_IDLE);

        // Encrypt and decrypt FIPS-197 C.3
        run_block("enc", 1'b0, 1'b0, 1'b0, 1'b0, PT, res);
        check("enc_ct", res, CT);
        run_block("dec", 1'b1, 1'b0, 1'b0, 1'b0, CT, res);
        check("dec_pt", res, PT);

        // start held high and inv_req toggled during the block
        run_block("spam", 1'b0, 1'b1, 1'b0, 1'b0, PT, res);
        check("spam_ct", res, CT);

        // Reset in round 7 MixColumns cnt 2
        @(negedge clk);
        start   = 1'b1;
        inv_req = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (current_state == S_MC && round == 4'd7 && cnt == 5'sd2) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_reached", found, 1'b1);
        d0    = done_total;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", current_state, S_IDLE);
        check("rst_mid_round", round, 0);
        check("rst_mid_cnt", cnt, 0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_mode", mode_switch, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", done_total, d0);
        check("rst_mid_idle", current_state, S_IDLE);
        run_block("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, PT, res);
        check("post_rst_ct", res, CT);

        // Back-to-back: second start in the IDLE cycle right after done
        run_block("b2b_a", 1'b0, 1'b0, 1'b1, 1'b0, PT, res);
        check("b2b_a_ct", res, CT);
        run_block("b2b_b", 1'b1, 1'b0, 1'b0, 1'b1, CT, res);
        check("b2b_b_pt", res, PT);
        check("b2b_done_period", last_done - prev_done, 391);

        check("invariants", bad_inv, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
